// File: rtl/mem_channel_arbiter_if.sv
// Consumer-side and memory-side request/response bundle for mem_channel_arbiter.
// Multi-element fields are flattened: element k lives in slice [k*W +: W].
interface mem_channel_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]            mem_write_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]            mem_write_ready;

    // Arbiter view
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    // Environment view: consumers plus memory
    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin sharing of NUM_CHANNELS memory channels among NUM_CONSUMERS requesters.
// Each channel relays one read or write at a time and hands the response back.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_channel_arbiter_if.slave bus
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
    } state_t;

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] cons_rd_addr, cons_wr_addr;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_wr_data;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_rd_data;
    logic [NUM_CONSUMERS-1:0]                cons_wr_vld;

    logic [NUM_CONSUMERS-1:0]                cons_rd_rdy_q, cons_wr_rdy_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_rd_data_q;
    logic [NUM_CHANNELS-1:0]                 mem_rd_vld_q, mem_wr_vld_q;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_rd_addr_q, mem_wr_addr_q;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_wr_data_q;

    state_t                  state     [NUM_CHANNELS];
    state_t                  state_nxt [NUM_CHANNELS];
    logic [CW-1:0]           owner     [NUM_CHANNELS];
    logic [CW-1:0]           rr_ptr    [NUM_CHANNELS];
    logic [CW-1:0]           grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] grant_vld, grant_rd;
    logic [NUM_CONSUMERS-1:0] claimed;

    assign cons_rd_addr = bus.consumer_read_address;
    assign cons_wr_addr = bus.consumer_write_address;
    assign cons_wr_data = bus.consumer_write_data;
    assign mem_rd_data  = bus.mem_read_data;
    // A read-only instance simply never sees write requests
    assign cons_wr_vld  = (WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0;

    assign bus.consumer_read_ready  = cons_rd_rdy_q;
    assign bus.consumer_read_data   = cons_rd_data_q;
    assign bus.consumer_write_ready = cons_wr_rdy_q;
    assign bus.mem_read_valid       = mem_rd_vld_q;
    assign bus.mem_read_address     = mem_rd_addr_q;
    assign bus.mem_write_valid      = mem_wr_vld_q;
    assign bus.mem_write_address    = mem_wr_addr_q;
    assign bus.mem_write_data       = mem_wr_data_q;

    // Lower channels grant first; their picks are hidden from higher channels.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found, is_rd;
        logic [CW-1:0]            sel;
        int                       idx;
        taken     = claimed;
        grant_vld = '0;
        grant_rd  = '0;
        idx       = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            is_rd = 1'b0;
            sel   = '0;
            if (state[c] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = int'(rr_ptr[c]) + k;
                    if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                    if (!found && !taken[idx] &&
                        (bus.consumer_read_valid[idx] || cons_wr_vld[idx])) begin
                        found = 1'b1;
                        sel   = CW'(idx);
                        is_rd = bus.consumer_read_valid[idx];
                    end
                end
                if (found) taken[sel] = 1'b1;
            end
            grant_vld[c] = found;
            grant_rd[c]  = is_rd;
            grant_idx[c] = sel;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_nxt[c] = state[c];
            case (state[c])
                IDLE:
                    if (grant_vld[c]) state_nxt[c] = grant_rd[c] ? READ_WAITING : WRITE_WAITING;
                READ_WAITING:
                    if (bus.mem_read_ready[c]) state_nxt[c] = READ_RELAYING;
                WRITE_WAITING:
                    if (bus.mem_write_ready[c]) state_nxt[c] = WRITE_RELAYING;
                READ_RELAYING:
                    if (!bus.consumer_read_valid[owner[c]]) state_nxt[c] = IDLE;
                WRITE_RELAYING:
                    if (!cons_wr_vld[owner[c]]) state_nxt[c] = IDLE;
                default:
                    state_nxt[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (reset) state[c] <= IDLE;
            else       state[c] <= state_nxt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            claimed        <= '0;
            cons_rd_rdy_q  <= '0;
            cons_wr_rdy_q  <= '0;
            cons_rd_data_q <= '0;
            mem_rd_vld_q   <= '0;
            mem_wr_vld_q   <= '0;
            mem_rd_addr_q  <= '0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rr_ptr[c] <= '0;
                owner[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (grant_vld[c]) begin
                        claimed[grant_idx[c]] <= 1'b1;
                        owner[c]  <= grant_idx[c];
                        rr_ptr[c] <= (int'(grant_idx[c]) == NUM_CONSUMERS - 1) ? '0
                                                                               : grant_idx[c] + 1'b1;
                        if (grant_rd[c]) begin
                            mem_rd_vld_q[c]  <= 1'b1;
                            mem_rd_addr_q[c] <= cons_rd_addr[grant_idx[c]];
                        end else begin
                            mem_wr_vld_q[c]  <= 1'b1;
                            mem_wr_addr_q[c] <= cons_wr_addr[grant_idx[c]];
                            mem_wr_data_q[c] <= cons_wr_data[grant_idx[c]];
                        end
                    end
                    READ_WAITING: if (bus.mem_read_ready[c]) begin
                        mem_rd_vld_q[c]          <= 1'b0;
                        cons_rd_data_q[owner[c]] <= mem_rd_data[c];
                        cons_rd_rdy_q[owner[c]]  <= 1'b1;
                    end
                    WRITE_WAITING: if (bus.mem_write_ready[c]) begin
                        mem_wr_vld_q[c]         <= 1'b0;
                        cons_wr_rdy_q[owner[c]] <= 1'b1;
                    end
                    READ_RELAYING: if (!bus.consumer_read_valid[owner[c]]) begin
                        cons_rd_rdy_q[owner[c]] <= 1'b0;
                        claimed[owner[c]]       <= 1'b0;
                    end
                    WRITE_RELAYING: if (!cons_wr_vld[owner[c]]) begin
                        cons_wr_rdy_q[owner[c]] <= 1'b0;
                        claimed[owner[c]]       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: cycle vector table on a 1-channel instance, then hand-written
// sequences for round-robin, read/write priority, reset abort, 2 channels and read-only.
module tb_mem_channel_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) ia ();
    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) ib ();

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                          .NUM_CHANNELS(1), .WRITE_ENABLE(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                          .NUM_CHANNELS(2), .WRITE_ENABLE(0))
        dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

    typedef struct packed {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] ra;
        logic        mrr;
        logic [7:0]  mrd;
        logic        e_mrv;
        logic [7:0]  e_mra;
        logic [3:0]  e_crr;
        logic [31:0] e_crd;
        logic [31:0] m_crd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        ia.consumer_read_valid = '0;  ia.consumer_read_address = '0;
        ia.consumer_write_valid = '0; ia.consumer_write_address = '0;
        ia.consumer_write_data = '0;  ia.mem_read_ready = '0;
        ia.mem_read_data = '0;        ia.mem_write_ready = '0;
    endtask

    task automatic clear_b();
        ib.consumer_read_valid = '0;  ib.consumer_read_address = '0;
        ib.consumer_write_valid = '0; ib.consumer_write_address = '0;
        ib.consumer_write_data = '0;  ib.mem_read_ready = '0;
        ib.mem_read_data = '0;        ib.mem_write_ready = '0;
    endtask

    task automatic reset_a();
        clear_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        clear_b();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [1:0] got;
        rst_a = 1'b1;
        rst_b = 1'b1;
        clear_a();
        clear_b();

        // rst rv ra mrr mrd | mrv mra crr crd mask
        vecs[0] = '{1'b1, 4'h0, 32'h0,         1'b0, 8'h00, 1'b0, 8'h00, 4'h0, 32'h0,         32'hFFFF_FFFF};
        vecs[1] = '{1'b0, 4'h4, 32'h001A_0000, 1'b0, 8'h00, 1'b1, 8'h1A, 4'h0, 32'h0,         32'hFFFF_FFFF};
        vecs[2] = '{1'b0, 4'h4, 32'h001A_0000, 1'b0, 8'h00, 1'b1, 8'h1A, 4'h0, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 4'h4, 32'h001A_0000, 1'b0, 8'h00, 1'b1, 8'h1A, 4'h0, 32'h0,         32'h0};
        vecs[4] = '{1'b0, 4'h4, 32'h001A_0000, 1'b1, 8'h5C, 1'b0, 8'h1A, 4'h4, 32'h005C_0000, 32'h00FF_0000};
        vecs[5] = '{1'b0, 4'h4, 32'h001A_0000, 1'b0, 8'h00, 1'b0, 8'h1A, 4'h4, 32'h005C_0000, 32'h00FF_0000};
        vecs[6] = '{1'b0, 4'h0, 32'h0,         1'b0, 8'h00, 1'b0, 8'h1A, 4'h0, 32'h0,         32'h0};
        // ready in the grant cycle must be ignored
        vecs[7] = '{1'b0, 4'h1, 32'h0000_0033, 1'b1, 8'hEE, 1'b1, 8'h33, 4'h0, 32'h0,         32'h0};
        vecs[8] = '{1'b0, 4'h1, 32'h0000_0033, 1'b1, 8'hA7, 1'b0, 8'h33, 4'h1, 32'h0000_00A7, 32'h0000_00FF};
        vecs[9] = '{1'b0, 4'h0, 32'h0,         1'b0, 8'h00, 1'b0, 8'h33, 4'h0, 32'h0,         32'h0};

        for (int i = 0; i < 10; i++) begin
            rst_a                    = vecs[i].rst;
            ia.consumer_read_valid   = vecs[i].rv;
            ia.consumer_read_address = vecs[i].ra;
            ia.mem_read_ready        = vecs[i].mrr;
            ia.mem_read_data         = vecs[i].mrd;
            tick();
            check($sformatf("vec%0d_mem_read_valid", i), ia.mem_read_valid, vecs[i].e_mrv);
            check($sformatf("vec%0d_mem_read_address", i), ia.mem_read_address, vecs[i].e_mra);
            check($sformatf("vec%0d_consumer_read_ready", i), ia.consumer_read_ready, vecs[i].e_crr);
            if (vecs[i].m_crd != 0)
                check($sformatf("vec%0d_consumer_read_data", i),
                      ia.consumer_read_data & vecs[i].m_crd, vecs[i].e_crd);
            check($sformatf("vec%0d_write_side_idle", i),
                  {ia.mem_write_valid, ia.consumer_write_ready}, 5'h0);
        end

        // Round-robin: all four keep requesting, expect 0,1,2,3,0
        reset_a();
        ia.consumer_read_address = 32'h1312_1110;
        ia.consumer_read_valid   = 4'hF;
        for (int g = 0; g < 5; g++) begin
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                tick();
                ok = ia.mem_read_valid[0];
            end
            check("rr_grant_seen", ok, 1'b1);
            got = ia.mem_read_address[1:0];
            check($sformatf("rr_order_%0d", g), ia.mem_read_address, 8'h10 + 8'(g % 4));
            ia.mem_read_ready = 1'b1;
            ia.mem_read_data  = 8'h80 + 8'(g);
            tick();
            ia.mem_read_ready = 1'b0;
            check($sformatf("rr_ready_%0d", g), ia.consumer_read_ready, 4'b1 << got);
            check($sformatf("rr_data_%0d", g), ia.consumer_read_data[got*8 +: 8], 8'h80 + 8'(g));
            ia.consumer_read_valid[got] = 1'b0;
            tick();
            check($sformatf("rr_ready_drop_%0d", g), ia.consumer_read_ready, 4'h0);
            ia.consumer_read_valid[got] = 1'b1;
        end

        // Read beats write for the same consumer; write follows
        reset_a();
        ia.consumer_read_valid    = 4'b0010;
        ia.consumer_read_address  = 32'h0000_0400;
        ia.consumer_write_valid   = 4'b0010;
        ia.consumer_write_address = 32'h0000_0800;
        ia.consumer_write_data    = 32'h0000_FF00;
        tick();
        check("prio_read_first", {ia.mem_read_valid, ia.mem_write_valid}, 2'b10);
        check("prio_read_addr", ia.mem_read_address, 8'h04);
        ia.mem_read_ready = 1'b1;
        ia.mem_read_data  = 8'h11;
        tick();
        ia.mem_read_ready = 1'b0;
        check("prio_read_ready", ia.consumer_read_ready, 4'b0010);
        ia.consumer_read_valid = '0;
        tick();
        check("prio_read_done", {ia.consumer_read_ready, ia.mem_write_valid}, 5'h0);
        tick();
        check("prio_write_grant", ia.mem_write_valid, 1'b1);
        check("prio_write_addr_data", {ia.mem_write_address, ia.mem_write_data}, 16'h08FF);
        ia.mem_write_ready = 1'b1;
        tick();
        ia.mem_write_ready = 1'b0;
        check("prio_write_ready", {ia.consumer_write_ready, ia.mem_write_valid}, 5'b00100);
        ia.consumer_write_valid = '0;
        tick();
        check("prio_write_ready_drop", ia.consumer_write_ready, 4'h0);

        // Reset while READ_WAITING aborts; rr_ptr back to 0 afterwards
        reset_a();
        ia.consumer_read_valid   = 4'b0010;
        ia.consumer_read_address = 32'h0000_7700;
        tick();
        check("abort_waiting", ia.mem_read_valid, 1'b1);
        rst_a = 1'b1;
        ia.consumer_read_valid = '0;
        tick();
        check("abort_read_outs", {ia.mem_read_valid, ia.mem_read_address,
                                  ia.consumer_read_ready, ia.consumer_read_data}, 45'h0);
        check("abort_write_outs", {ia.mem_write_valid, ia.mem_write_address,
                                   ia.mem_write_data, ia.consumer_write_ready}, 21'h0);
        rst_a = 1'b0;
        ia.consumer_read_valid   = 4'b1010;
        ia.consumer_read_address = 32'h6600_5500;
        tick();
        check("abort_regrant_valid", ia.mem_read_valid, 1'b1);
        check("abort_regrant_rr0", ia.mem_read_address, 8'h55);

        // Two channels: consumers 0 and 3 at once
        reset_b();
        ib.consumer_read_valid   = 4'b1001;
        ib.consumer_read_address = 32'h2300_0020;
        tick();
        check("ch2_both_valid", ib.mem_read_valid, 2'b11);
        check("ch2_addrs", ib.mem_read_address, 16'h2320);
        ib.mem_read_ready = 2'b11;
        ib.mem_read_data  = 16'hB3B0;
        tick();
        ib.mem_read_ready = 2'b00;
        check("ch2_ready", {ib.consumer_read_ready, ib.mem_read_valid}, 6'b100100);
        check("ch2_data", ib.consumer_read_data & 32'hFF00_00FF, 32'hB300_00B0);
        ib.consumer_read_valid = '0;
        tick();
        check("ch2_ready_drop", ib.consumer_read_ready, 4'h0);
        ib.consumer_read_valid   = 4'b0001;
        ib.consumer_read_address = 32'h0000_0021;
        tick();
        check("ch2_single_claim", ib.mem_read_valid, 2'b01);
        check("ch2_single_addr", ib.mem_read_address[7:0], 8'h21);
        ib.mem_read_ready = 2'b01;
        ib.mem_read_data  = 16'h0042;
        tick();
        ib.mem_read_ready = '0;
        ib.consumer_read_valid = '0;
        check("ch2_single_ready", ib.consumer_read_ready, 4'b0001);
        tick();

        // Read-only instance: write on consumer 0 held 20 cycles, read on consumer 2
        reset_b();
        ib.consumer_write_valid   = 4'b0001;
        ib.consumer_write_address = 32'h0000_0030;
        ib.consumer_write_data    = 32'h0000_00AA;
        ib.consumer_read_valid    = 4'b0100;
        ib.consumer_read_address  = 32'h0042_0000;
        tick();
        check("ro_read_grant", ib.mem_read_valid, 2'b01);
        check("ro_read_addr", ib.mem_read_address[7:0], 8'h42);
        check("ro_no_write_0", {ib.mem_write_valid, ib.consumer_write_ready}, 6'h0);
        ib.mem_read_ready = 2'b01;
        ib.mem_read_data  = 16'h009D;
        tick();
        ib.mem_read_ready = '0;
        check("ro_read_ready", ib.consumer_read_ready, 4'b0100);
        check("ro_read_data", ib.consumer_read_data[23:16], 8'h9D);
        ib.consumer_read_valid = '0;
        for (int t = 2; t < 20; t++) begin
            tick();
            check($sformatf("ro_no_write_%0d", t),
                  {ib.mem_write_valid, ib.consumer_write_ready, ib.mem_read_valid}, 8'h0);
        end
        check("ro_write_outs_zero", {ib.mem_write_address, ib.mem_write_data}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares NUM_CHANNELS external memory channels among NUM_CONSUMERS requesters (per-core LSUs or fetchers) using round-robin arbitration.
- Each channel runs a small relay FSM. It forwards one read or write from the granted consumer to memory, then returns the memory response to that consumer.
- Sits between the cores launched by the block dispatcher and the external data/program memory ports.
- All multi-consumer and multi-channel ports are flattened vectors; element k occupies slice [k*W +: W].

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width
NUM_CONSUMERS, 4, number of requesters
NUM_CHANNELS, 1, number of concurrent memory channels (1..NUM_CONSUMERS)
WRITE_ENABLE, 1, 0 = read-only instance (program memory); write ports unused

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  read request per consumer
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read addresses
consumer_read_ready  out  NUM_CONSUMERS  read data valid / request complete
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  read data
consumer_write_valid  in  NUM_CONSUMERS  write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write addresses
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data
consumer_write_ready  out  NUM_CONSUMERS  write complete
mem_read_valid  out  NUM_CHANNELS  read request to memory
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  read address
mem_read_ready  in  NUM_CHANNELS  memory read done, data valid this cycle
mem_read_data  in  NUM_CHANNELS*DATA_BITS  memory read data
mem_write_valid  out  NUM_CHANNELS  write request to memory
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  write address
mem_write_data  out  NUM_CHANNELS*DATA_BITS  write data
mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - All outputs are 0.
  - Every channel is IDLE.
  - All consumer claims are cleared.
  - Every rr_ptr is 0.
- Consumer protocol:
  - valid and address/data are held until the matching ready is seen.
  - valid then drops; ready drops the cycle after valid is seen low.
- Per-channel FSM states:
  - IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE arbitration:
  - The channel scans consumers starting at rr_ptr[c] and wrapping modulo NUM_CONSUMERS.
  - It takes the first consumer that is unclaimed and has read_valid or write_valid set.
  - Read beats write for the same consumer.
  - In one cycle, channels grant in ascending index order. A consumer claimed by a lower channel this cycle is invisible to higher channels.
  - On grant to consumer j:
    - The claim is set and rr_ptr[c] <= (j+1) mod NUM_CONSUMERS.
    - The address (and write data) is registered onto the mem port and mem_*_valid[c] <= 1. This is 1 cycle of latency from the valid being sampled.
    - Next state is READ_WAITING or WRITE_WAITING.
- READ_WAITING:
  - On mem_read_ready[c]: mem_read_valid[c] <= 0, consumer_read_data[j] <= mem_read_data[c], consumer_read_ready[j] <= 1, then go to READ_RELAYING.
- WRITE_WAITING:
  - On mem_write_ready[c]: mem_write_valid[c] <= 0, consumer_write_ready[j] <= 1, then go to WRITE_RELAYING.
- *_RELAYING:
  - When consumer *_valid[j] == 0: ready[j] <= 0, clear the claim on j, then go to IDLE.
  - The channel can grant again on the cycle after it returns to IDLE.
- Address and data outputs hold their values from grant until the next grant. They are don't-care while valid is 0 but must not glitch while valid is 1.
- When WRITE_ENABLE = 0:
  - Write requests are never granted.
  - consumer_write_ready and all mem_write_* outputs stay 0.
- Boundary rules:
  - NUM_CHANNELS == NUM_CONSUMERS: every consumer can be serviced concurrently.
  - If mem ready arrives in the same cycle as the grant, it is ignored (valid is not yet asserted).
  - rr_ptr wraps from NUM_CONSUMERS-1 to 0.
- Reset mid-transaction: everything aborts immediately. Consumers must re-issue their requests.
- Fairness: with all consumers continuously requesting and NUM_CHANNELS = 1, grants cycle 0,1,2,3,0,… with no starvation.

Test Plan:
- Single read, default params:
  - Stimulus: consumer 2 requests read addr 0x1A; memory returns 0x5C three cycles after valid.
  - Required: mem_read_valid[0] = 1 the cycle after the request; consumer_read_ready[2] = 1 with data 0x5C one cycle after mem ready; channel IDLE two cycles after consumer valid drops.
- Round-robin:
  - Stimulus: consumers 0–3 request reads simultaneously and re-request immediately.
  - Required: grant order 0,1,2,3,0; no consumer served twice before all are served.
- Read/write priority:
  - Stimulus: consumer 1 asserts read (addr 0x04) and write (addr 0x08, data 0xFF) together.
  - Required: read is granted first; the write (0x08/0xFF) follows after the read completes.
- NUM_CHANNELS = 2:
  - Stimulus: consumers 0 and 3 request together.
  - Required: channel 0 serves consumer 0 and channel 1 serves consumer 3 in the same cycle; no double claim.
- Reset mid-transaction:
  - Stimulus: assert reset while in READ_WAITING.
  - Required: all outputs are 0 next cycle; after release, a new request is granted normally with rr_ptr = 0.
- WRITE_ENABLE = 0:
  - Stimulus: consumer 0 asserts write for 20 cycles.
  - Required: no mem_write_valid, consumer_write_ready stays 0, reads still serviced.
